// File: rtl/requant_sched.sv
// requant_sched: schedules four request channels onto one shared multi-cycle
// requantizer. A channel is picked and its sample and Nquant are launched.
// The result is sampled a fixed WAIT_CYC cycles later and tagged with its channel.
// Optional feature macro: RQ_SCHED_RR_EN. When defined, arbitration is
// round-robin. When undefined, arbitration is fixed priority with channel 0
// highest.
module requant_sched #(
  parameter int unsigned WAIT_CYC = 40   // legal 40..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ch,
  input  logic [4:0]  cfg_nquant,
  input  logic [3:0]  req,
  input  logic [71:0] din,
  output logic [3:0]  gnt,
  output logic        rq_reset,
  output logic [4:0]  rq_nquant,
  output logic [17:0] rq_datain,
  output logic        rq_endatain,
  input  logic [17:0] rq_dataout,
  output logic [17:0] dout,
  output logic [1:0]  dout_ch,
  output logic        dout_valid,
  output logic        busy
);

  localparam int NCH = 4;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      rst_cnt_q;
  logic [NCH-1:0][4:0] nq_q;
  logic [4:0]      rqn_q;
  logic [17:0]     dat_q;
  logic [17:0]     dout_q;
  logic [1:0]      dout_ch_q;
  logic [17:0]     din_ch [NCH];
  logic [1:0]      pick;
  logic            launch;

  // Clamp a configured Nquant into the requantizer's legal 1..17 range.
  function automatic logic [4:0] clamp_nq(input logic [4:0] v);
    if (v == 5'd0)       return 5'd1;
    else if (v > 5'd17)  return 5'd17;
    else                 return v;
  endfunction

  // Split the packed sample bus into per-channel slices.
  always_comb begin
    for (int i = 0; i < NCH; i++) din_ch[i] = din[i*18 +: 18];
  end

`ifdef RQ_SCHED_RR_EN
  logic [1:0] ptr_q;   // channel where the next search starts

  // Round-robin pick: the first requester at or after the pointer.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // After a grant, the search restarts one past the granted channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       ptr_q <= 2'd0;
    else if (launch) ptr_q <= pick + 2'd1;
  end
`else
  // Fixed-priority pick: the lowest-index requester wins.
  always_comb begin
    pick = 2'd0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (req[k]) pick = 2'(k);
    end
  end
`endif

  // FSM next state. Launch is held off while the requantizer is in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req && !rq_reset) begin
          launch  = 1'b1;
          sel_d   = pick;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = 8'(WAIT_CYC - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, wait counter and selected-channel registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Hold the requantizer in reset for two cycles after the master reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  rst_cnt_q <= 2'd2;
    else if (rst_cnt_q != 2'd0) rst_cnt_q <= rst_cnt_q - 2'd1;
  end

  // Per-channel Nquant. A launch in the same cycle reads the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) nq_q[i] <= 5'd17;
    end else if (cfg_we) begin
      nq_q[cfg_ch] <= clamp_nq(cfg_nquant);
    end
  end

  // Requantizer operands are latched at launch and held until the next launch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dat_q <= 18'd0;
      rqn_q <= 5'd0;
    end else if (launch) begin
      dat_q <= din_ch[pick];
      rqn_q <= nq_q[pick];
    end
  end

  // Capture the result on the WAIT->DONE edge. It holds until the next DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q    <= 18'd0;
      dout_ch_q <= 2'd0;
    end else if (state_q == S_WAIT && cnt_q == 8'd0) begin
      dout_q    <= rq_dataout;
      dout_ch_q <= sel_q;
    end
  end

  assign rq_reset    = (rst_cnt_q != 2'd0);
  assign gnt         = (state_q == S_LAUNCH) ? (4'b0001 << sel_q) : 4'b0000;
  assign rq_endatain = (state_q == S_LAUNCH);
  assign rq_datain   = dat_q;
  assign rq_nquant   = rqn_q;
  assign dout        = dout_q;
  assign dout_ch     = dout_ch_q;
  assign dout_valid  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_requant_sched.sv
// Bench for requant_sched: randomized transactions against a transaction-level
// model (per-channel Nquant table, arbitration order, expected result).
module tb_requant_sched;
  localparam int W = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [4:0]  cfg_nquant = 5'd0;
  logic [3:0]  req = 4'd0;
  logic [71:0] din = 72'd0;
  logic [3:0]  gnt;
  logic        rq_reset, rq_endatain, dout_valid, busy;
  logic [4:0]  rq_nquant;
  logic [17:0] rq_datain, rq_dataout, dout;
  logic [1:0]  dout_ch;

  requant_sched #(.WAIT_CYC(W)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_nquant(cfg_nquant), .req(req), .din(din), .gnt(gnt),
    .rq_reset(rq_reset), .rq_nquant(rq_nquant), .rq_datain(rq_datain),
    .rq_endatain(rq_endatain), .rq_dataout(rq_dataout), .dout(dout),
    .dout_ch(dout_ch), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Stand-in requantizer: any function sensitive to both operands.
  function automatic logic [17:0] rq_fn(input logic [17:0] d, input logic [4:0] n);
    return 18'((d >> n) + {n, 13'h0} ^ 18'h00A5);
  endfunction
  assign rq_dataout = rq_fn(rq_datain, rq_nquant);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state
  int          nq_m [4];
  int          ptr_m;
  logic [17:0] last_dout;

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : (v > 17) ? 17 : v;
  endfunction

  function automatic int arb(input logic [3:0] r);
`ifdef RQ_SCHED_RR_EN
    for (int k = 0; k < 4; k++) if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) nq_m[i] = 17;
    ptr_m = 0;
    last_dout = 18'd0;
  endtask

  // Pulse reset while r is held. No grant may appear during the two rq_reset cycles.
  task automatic do_reset(input logic [3:0] r);
    @(negedge clock);
    reset = 1'b1; req = r; cfg_we = 1'b0;
    @(negedge clock);
    chk("rst_gnt", gnt, 0);        chk("rst_endat", rq_endatain, 0);
    chk("rst_datain", rq_datain, 0); chk("rst_nq", rq_nquant, 0);
    chk("rst_dout", dout, 0);      chk("rst_dch", dout_ch, 0);
    chk("rst_valid", dout_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_rqrst", rq_reset, 1);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    chk("rqrst1", rq_reset, 1); chk("rqrst1_gnt", gnt, 0); chk("rqrst1_busy", busy, 0);
    @(negedge clock);
    chk("rqrst2", rq_reset, 0); chk("rqrst2_gnt", gnt, 0); chk("rqrst2_busy", busy, 0);
  endtask

  task automatic cfg_write(input int ch, input int v);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_nquant = 5'(v);
    nq_m[ch] = clamp(v);
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  // One transaction. It is entered and left on a negedge with the FSM in IDLE.
  // mode 0: plain. 1: cfg write to the granted channel in the launch cycle.
  // mode 2: cfg write to the in-flight channel during WAIT.
  // mode 3: a transient req burst during WAIT that must not be remembered.
  task automatic txn(input logic [3:0] r, input logic [71:0] d, input int mode, input int cv);
    int s, nq;
    logic [17:0] sl, ex;
    req = r; din = d;
    s  = arb(r);
    nq = nq_m[s];
    sl = d[s*18 +: 18];
    ex = rq_fn(sl, 5'(nq));
`ifdef RQ_SCHED_RR_EN
    ptr_m = (s + 1) % 4;
`endif
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_ch = 2'(s); cfg_nquant = 5'(cv); nq_m[s] = clamp(cv);
    end
    @(negedge clock);
    cfg_we = 1'b0;
    req = r & ~(4'b0001 << s);
    chk("gnt", gnt, 32'(1) << s); chk("endatain", rq_endatain, 1); chk("busy", busy, 1);
    chk("datain", rq_datain, sl); chk("nquant", rq_nquant, nq);
    for (int c = 0; c < W; c++) begin
      @(negedge clock);
      if (mode == 2 && c == 2) begin
        cfg_we = 1'b1; cfg_ch = 2'(s); cfg_nquant = 5'(cv); nq_m[s] = clamp(cv);
      end
      if (c == 3) cfg_we = 1'b0;
      if (mode == 3 && c == 5)  req = 4'b1111;
      if (mode == 3 && c == 10) req = 4'b0000;
      chk("wait_gnt", gnt, 0); chk("wait_valid", dout_valid, 0); chk("wait_endat", rq_endatain, 0);
      chk("hold_datain", rq_datain, sl); chk("hold_nq", rq_nquant, nq);
      chk("hold_dout", dout, last_dout);
    end
    @(negedge clock);
    chk("done_valid", dout_valid, 1); chk("done_dout", dout, ex); chk("done_ch", dout_ch, s);
    chk("done_datain", rq_datain, sl); chk("done_nq", rq_nquant, nq); chk("done_gnt", gnt, 0);
    last_dout = ex;
    req = 4'b0000;
    @(negedge clock);
    chk("idle_valid", dout_valid, 0); chk("idle_busy", busy, 0); chk("idle_dout", dout, ex);
  endtask

  function automatic logic [71:0] rnd72();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[71:0];
  endfunction

  initial begin
    logic [71:0] d;
    model_reset();

    // Basic launch with default Nquant 17. req is held through reset.
    do_reset(4'b0001);
    d = rnd72(); d[17:0] = 18'h12345;
    txn(4'b0001, d, 0, 0);

    // Configured Nquant on channel 1.
    cfg_write(1, 4);
    d = rnd72(); d[35:18] = 18'h2A000;
    txn(4'b0010, d, 0, 0);

    // Clamping of Nquant writes, and a write to the in-flight channel.
    cfg_write(2, 0);
    txn(4'b0100, rnd72(), 0, 0);
    cfg_write(2, 25);
    txn(4'b0100, rnd72(), 0, 0);
    txn(4'b0100, rnd72(), 2, 5);
    txn(4'b0100, rnd72(), 0, 0);

    // A cfg write in the same cycle as the launch uses the old value.
    txn(4'b0001, rnd72(), 1, 3);
    txn(4'b0001, rnd72(), 0, 0);

    // All channels requesting back to back.
    for (int i = 0; i < 5; i++) txn(4'b1111, rnd72(), 0, 0);

    // A transient request seen only while busy is not queued.
    txn(4'b1000, rnd72(), 3, 0);
    txn(4'b0100, rnd72(), 0, 0);

    // Randomized transactions.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      txn(r, rnd72(), $urandom_range(0, 3), $urandom_range(0, 31));
    end

    // Reset during WAIT aborts the transaction. Recovery is then normal.
    cfg_write(3, 9);
    req = 4'b1000; din = rnd72();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      req = 4'b0000;
      chk("abort_valid", dout_valid, 0);
    end
    do_reset(4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_abort_idle", busy, 0); chk("post_abort_valid", dout_valid, 0);
    end
    txn(4'b1000, rnd72(), 0, 0);
    txn(4'b0110, rnd72(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/requant_sched.md
REQUANT_SCHED -- requirements
Module: requant_sched

Interface
REQ-001 Parameter WAIT_CYC, default 40, SHALL set the number of cycles waited after launch before the requantizer result is sampled; legal range is 40..255.
REQ-002 Port clock, input, 1 bit, SHALL be the master clock; all logic is rising-edge.
REQ-003 Port reset, input, 1 bit, SHALL be the master reset, asynchronous, active high.
REQ-004 Port cfg_we, input, 1 bit, SHALL be the per-channel Nquant write strobe.
REQ-005 Port cfg_ch, input, 2 bits, SHALL be the channel index for a cfg write.
REQ-006 Port cfg_nquant, input, 5 bits, SHALL be the Nquant value to write.
REQ-007 Port req, input, 4 bits, SHALL carry the per-channel request, held high until granted.
REQ-008 Port din, input, 72 bits, SHALL carry the channel i sample in bits [18i+17:18i].
REQ-009 Port gnt, output, 4 bits, SHALL be a one-hot, one-cycle accept pulse.
REQ-010 Port rq_reset, output, 1 bit, SHALL be the synchronous reset to the requantizer.
REQ-011 Ports rq_nquant (5 bits), rq_datain (18 bits) and rq_endatain (1 bit), outputs, SHALL drive the requantizer.
REQ-012 Port rq_dataout, input, 18 bits, SHALL carry the requantizer result.
REQ-013 Ports dout (18 bits), dout_ch (2 bits) and dout_valid (1 bit), outputs, SHALL carry the result, its channel tag and a one-cycle valid strobe.
REQ-014 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT and DONE, with one-way transitions IDLE->LAUNCH->WAIT->DONE->IDLE.
REQ-016 IDLE with any req bit high and rq_reset low SHALL select one channel, latch its din slice and Nquant into rq_datain/rq_nquant, and go to LAUNCH.
REQ-017 In LAUNCH, gnt[sel] and rq_endatain SHALL be high for exactly that cycle.
REQ-018 rq_datain and rq_nquant SHALL stay constant from LAUNCH through DONE, since the requantizer reads datain over several cycles.
REQ-019 WAIT SHALL last exactly WAIT_CYC cycles, counted by an 8-bit down-counter.
REQ-020 Entering DONE SHALL register dout<=rq_dataout and dout_ch<=sel, with dout_valid high only in DONE.
REQ-021 The timing SHALL be: req seen in IDLE in cycle T gives gnt in T+1 and dout_valid in T+2+WAIT_CYC; back-to-back transactions SHALL occur every WAIT_CYC+3 cycles.
REQ-022 dout and dout_ch SHALL hold their values until the next DONE.
REQ-023 Per-channel Nquant registers SHALL be 5 bits wide; a cfg write of 0 SHALL store 1, a write above 17 SHALL store 17, and any other value SHALL be stored as written.
REQ-024 A cfg write SHALL be accepted in any state; a write to the in-flight channel SHALL affect only later transactions.
REQ-025 A cfg write and a launch on the same channel in the same cycle SHALL launch with the old value.
REQ-026 A req bit that drops before grant SHALL be ignored without error.
REQ-027 req bits arriving while busy SHALL wait; nothing is queued beyond the req level.

Reset
REQ-028 While reset is high: state=IDLE, gnt=0, rq_endatain=0, rq_datain=0, rq_nquant=0, dout=0, dout_ch=0, dout_valid=0, busy=0, all channel Nquant=17, RR pointer=0, WAIT counter=0.
REQ-029 rq_reset SHALL be high during reset and for exactly 2 clock cycles after reset deasserts; no launch SHALL occur while rq_reset is high.
REQ-030 Reset asserted mid-transaction SHALL abort it with no dout_valid, and the aborted request SHALL NOT be granted.

Configuration
REQ-031 Macro RQ_SCHED_RR_EN SHALL select the arbitration scheme.
REQ-032 With RQ_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at the channel after the last granted, and the pointer updates on each grant.
REQ-033 Without RQ_SCHED_RR_EN, arbitration SHALL be fixed priority, channel 0 highest, and no pointer register SHALL exist.

Verification
REQ-034 Reset, then req=0001, din[17:0]=18'h12345 with default Nquant 17 -> rq_reset high for 2 cycles, gnt=0001 at T+1, dout_valid at T+42, dout_ch=0.
REQ-035 cfg ch1=4, req=0010, din ch1=18'h2A000 -> dout equals the requantizer output for (18'h2A000, 4); rq_datain and rq_nquant stable through DONE.
REQ-036 req=1111 held with RR_EN -> grants 0001,0010,0100,1000,0001 at 43-cycle spacing; without RR_EN -> gnt=0001 repeatedly.
REQ-037 cfg writes of 0 and 25 to ch2 -> stored values 1 and 17; a write to the in-flight channel leaves the current rq_nquant unchanged.
REQ-038 Reset pulsed during WAIT -> no dout_valid, all outputs 0, and the next transaction after the 2-cycle rq_reset completes normally.
